// File: rtl/vga_plot_arbiter.sv
// Arbitrates processor pixel writes and full-screen clears onto a single registered VGA write port.
// Defining VGA_ARB_ABORT_EN adds a clr_abort input that ends a running clear early.
module vga_plot_arbiter #(
  parameter logic [7:0] XMAX = 8'd159,
  parameter logic [7:0] YMAX = 8'd119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic [7:0] cpu_x,
  input  logic [7:0] cpu_y,
  input  logic [2:0] cpu_color,
  output logic       cpu_ack,
  input  logic       clr_req,
  input  logic [2:0] clr_color,
`ifdef VGA_ARB_ABORT_EN
  input  logic       clr_abort,
`endif
  output logic       clr_busy,
  output logic       clr_done,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [2:0] color_draw,
  output logic       plot,
  output logic [1:0] state_dbg
);

  // Handshake: cpu_req is a level held by the processor until it sees the
  // one-cycle cpu_ack pulse; the pixel is written in that same cycle, and the
  // arbiter waits for cpu_req to drop before accepting another request.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_PLOT = 2'd1,
    CPU_WAIT = 2'd2,
    CLEAR    = 2'd3
  } state_t;

  state_t     state, state_d;
  logic [7:0] x_d, y_d;
  logic [2:0] color_d;
  logic       plot_d, ack_d, busy_d, done_d;
  logic       abort;
  logic       sweep_last;

`ifdef VGA_ARB_ABORT_EN
  assign abort = clr_abort;
`else
  assign abort = 1'b0;
`endif

  // x/y double as the sweep counters: during CLEAR they always equal the pixel on the port.
  assign sweep_last = (x == XMAX) && (y == YMAX);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      x          <= 8'd0;
      y          <= 8'd0;
      color_draw <= 3'd0;
      plot       <= 1'b0;
      cpu_ack    <= 1'b0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
    end else begin
      state      <= state_d;
      x          <= x_d;
      y          <= y_d;
      color_draw <= color_d;
      plot       <= plot_d;
      cpu_ack    <= ack_d;
      clr_busy   <= busy_d;
      clr_done   <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    color_d = color_draw;
    plot_d  = 1'b0;
    ack_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        // Clear has priority; a simultaneous cpu_req simply stays pending.
        if (clr_req) begin
          state_d = CLEAR;
          x_d     = 8'd0;
          y_d     = 8'd0;
          color_d = clr_color;
          plot_d  = 1'b1;
          busy_d  = 1'b1;
        end else if (cpu_req) begin
          state_d = CPU_PLOT;
          x_d     = cpu_x;
          y_d     = cpu_y;
          color_d = cpu_color;
          plot_d  = 1'b1;
          ack_d   = 1'b1;
        end
      end
      CPU_PLOT: state_d = CPU_WAIT;
      CPU_WAIT: begin
        if (!cpu_req) state_d = IDLE;
      end
      CLEAR: begin
        if (abort || sweep_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          plot_d = 1'b1;
          busy_d = 1'b1;
          if (x == XMAX) begin
            x_d = 8'd0;
            y_d = y + 8'd1;
          end else begin
            x_d = x + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: pixel scoreboard fed from a nested-loop screen model,
// directed handshake/clear/reset scenarios and randomized processor pixels.
module tb_vga_plot_arbiter;

  localparam int XN = 160;
  localparam int YN = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_req = 1'b0;
  logic [7:0] cpu_x = 8'd0;
  logic [7:0] cpu_y = 8'd0;
  logic [2:0] cpu_color = 3'd0;
  logic       cpu_ack;
  logic       clr_req = 1'b0;
  logic [2:0] clr_color = 3'd0;
`ifdef VGA_ARB_ABORT_EN
  logic       clr_abort = 1'b0;
`endif
  logic       clr_busy;
  logic       clr_done;
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] color_draw;
  logic       plot;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;
  logic [18:0] exp_q[$];

  vga_plot_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_x      (cpu_x),
    .cpu_y      (cpu_y),
    .cpu_color  (cpu_color),
    .cpu_ack    (cpu_ack),
    .clr_req    (clr_req),
    .clr_color  (clr_color),
`ifdef VGA_ARB_ABORT_EN
    .clr_abort  (clr_abort),
`endif
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .x          (x),
    .y          (y),
    .color_draw (color_draw),
    .plot       (plot),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every plot cycle must match the next expected pixel in order
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 32'(plot), 32'd0);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("pixel", 32'({x, y, color_draw}), 32'(e));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_clear(input logic [2:0] c);
    for (int yy = 0; yy < YN; yy++)
      for (int xx = 0; xx < XN; xx++)
        exp_q.push_back({8'(xx), 8'(yy), c});
  endtask

  task automatic cpu_pixel(input logic [7:0] px, input logic [7:0] py, input logic [2:0] pc,
                           input int hold, input logic poke_clr);
    cpu_x = px;
    cpu_y = py;
    cpu_color = pc;
    cpu_req = 1'b1;
    exp_q.push_back({px, py, pc});
    step();
    check("cpu_ack", 32'(cpu_ack), 32'd1);
    check("cpu_plot", 32'(plot), 32'd1);
    step();
    check("cpu_ack_once", 32'(cpu_ack), 32'd0);
    check("wait_plot", 32'(plot), 32'd0);
    check("hold_x", 32'(x), 32'(px));
    check("hold_y", 32'(y), 32'(py));
    for (int i = 0; i < hold; i++) begin
      clr_req = poke_clr;
      cpu_x = 8'($urandom_range(0, 159));
      step();
      check("wait_noack", 32'(cpu_ack), 32'd0);
      check("wait_nobusy", 32'(clr_busy), 32'd0);
    end
    clr_req = 1'b0;
    cpu_req = 1'b0;
    step();
    check("idle_noack", 32'(cpu_ack), 32'd0);
    check("idle_color_hold", 32'(color_draw), 32'(pc));
  endtask

  task automatic sweep(input int budget, output int nplot, output int ndone);
    nplot = 0;
    ndone = 0;
    for (int i = 0; i < budget && ndone == 0; i++) begin
      step();
      clr_req = 1'b0;
      if (i == 0) check("clr_first_latency", 32'(plot), 32'd1);
      if (plot === 1'b1) begin
        nplot++;
        check("clr_busy_on", 32'(clr_busy), 32'd1);
        check("no_ack_in_clear", 32'(cpu_ack), 32'd0);
      end
      if (clr_done === 1'b1) begin
        ndone++;
        check("done_plot", 32'(plot), 32'd0);
        check("done_busy", 32'(clr_busy), 32'd0);
      end
    end
  endtask

  initial begin
    int np, nd;
    logic found;

    // reset state
    step();
    step();
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_color", 32'(color_draw), 32'd0);
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_done", 32'(clr_done), 32'd0);
    reset = 1'b1;

    // directed processor pixel, held request must not be re-acknowledged
    cpu_pixel(8'd10, 8'd20, 3'd5, 3, 1'b0);

    // full clear at default size
    fill_clear(3'd2);
    clr_color = 3'd2;
    clr_req = 1'b1;
    sweep(20000, np, nd);
    check("clr_count", 32'(np), 32'(XN * YN));
    check("clr_done_seen", 32'(nd), 32'd1);
    step();
    check("clr_done_pulse", 32'(clr_done), 32'd0);
    check("clr_busy_off", 32'(clr_busy), 32'd0);
    check("clr_hold_x", 32'(x), 32'd159);
    check("clr_hold_y", 32'(y), 32'd119);

    // simultaneous clear and processor request: clear first, then the held pixel
    fill_clear(3'd6);
    exp_q.push_back({8'd3, 8'd4, 3'd7});
    cpu_x = 8'd3;
    cpu_y = 8'd4;
    cpu_color = 3'd7;
    cpu_req = 1'b1;
    clr_color = 3'd6;
    clr_req = 1'b1;
    sweep(20000, np, nd);
    check("both_clr_count", 32'(np), 32'(XN * YN));
    check("both_done_seen", 32'(nd), 32'd1);
    step();
    check("ack_after_clear", 32'(cpu_ack), 32'd1);
    check("ack_after_clear_plot", 32'(plot), 32'd1);
    step();
    cpu_req = 1'b0;
    step();

    // asynchronous reset in the middle of a clear
    fill_clear(3'd3);
    clr_color = 3'd3;
    clr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      clr_req = 1'b0;
      if (plot === 1'b1 && x == 8'd37 && y == 8'd4) found = 1'b1;
    end
    check("reach_37_4", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    check("arst_plot", 32'(plot), 32'd0);
    check("arst_x", 32'(x), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    check("arst_color", 32'(color_draw), 32'd0);
    check("arst_busy", 32'(clr_busy), 32'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_no_done", 32'(clr_done), 32'd0);
    end
    reset = 1'b1;

    // restart after reset begins at (0,0); stop it again with reset after a few pixels
    for (int xx = 0; xx < 12; xx++) exp_q.push_back({8'(xx), 8'd0, 3'd4});
    clr_color = 3'd4;
    clr_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      clr_req = 1'b0;
    end
    check("restart_x", 32'(x), 32'd11);
    check("restart_queue", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_q.delete();

`ifdef VGA_ARB_ABORT_EN
    // abort at pixel (5,0)
    for (int xx = 0; xx < 6; xx++) exp_q.push_back({8'(xx), 8'd0, 3'd5});
    clr_color = 3'd5;
    clr_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      clr_req = 1'b0;
      if (plot === 1'b1 && x == 8'd5 && y == 8'd0) found = 1'b1;
    end
    check("reach_5_0", 32'(found), 32'd1);
    clr_abort = 1'b1;
    step();
    clr_abort = 1'b0;
    check("abort_plot", 32'(plot), 32'd0);
    check("abort_done", 32'(clr_done), 32'd1);
    check("abort_busy", 32'(clr_busy), 32'd0);
    step();
    check("abort_done_pulse", 32'(clr_done), 32'd0);
    check("abort_idle_plot", 32'(plot), 32'd0);
`endif

    // randomized processor pixels, with stray clr_req during the wait phase
    for (int n = 0; n < 40; n++) begin
      cpu_pixel(8'($urandom_range(0, 159)), 8'($urandom_range(0, 119)),
                3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
